// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Request/response bundle between the core datapath and the
//                load/store unit (address, store data, control, load data,
//                stall and misalignment status).
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic [31:0] A;
    logic [31:0] WD;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] RD;
    logic        Stall;
    logic        Misalign;
    logic        Fault;
    logic [31:0] FaultAddr;

    modport master (
        output A, WD, MemRead, MemWrite, Funct3,
        input  RD, Stall, Misalign, Fault, FaultAddr
    );

    modport slave (
        input  A, WD, MemRead, MemWrite, Funct3,
        output RD, Stall, Misalign, Fault, FaultAddr
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I data-memory stage. Byte/half/word loads and stores
//                against an internal word-organised RAM, a wait-state counter
//                that stalls the PC, and optional misalignment trapping
//                enabled by the LSU_MISALIGN_TRAP_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam int         c_IDX_W = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic               w_mis;
    logic               w_go;
    logic               w_stall;
    logic               w_done;
    logic               w_is_half;
    logic               w_is_word;
    logic [1:0]         w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_word;
    logic [31:0]        w_lane;
    logic [31:0]        w_rd;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;

    assign w_req = bus.MemRead | bus.MemWrite;
    assign w_idx = bus.A[c_IDX_W+1:2];

    // Access-size decode; store-only codes 1xx never count as halfword
    always_comb begin
        w_is_word = (bus.Funct3 == 3'b010);
        w_is_half = (bus.Funct3[1:0] == 2'b01) && !(bus.MemWrite && bus.Funct3[2]);
        // Lane offset is forced aligned; misaligned requests never reach the RAM
        if (w_is_word) begin
            w_off = 2'b00;
        end else if (w_is_half) begin
            w_off = {bus.A[1], 1'b0};
        end else begin
            w_off = bus.A[1:0];
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis = rst & w_req &
                   ((w_is_half & bus.A[0]) | (w_is_word & (bus.A[1:0] != 2'b00)));
`else
    assign w_mis = 1'b0;
`endif

    assign w_go    = rst & w_req & ~w_mis;
    assign w_stall = w_go & (r_cnt != c_WAIT);
    assign w_done  = w_go & (r_cnt == c_WAIT);

    assign w_word = r_mem[w_idx];
    assign w_lane = w_word >> {w_off, 3'b000};

    // Load data: extended only in the completion cycle of a pure load
    always_comb begin
        w_rd = 32'd0;
        if (w_done && bus.MemRead && !bus.MemWrite) begin
            case (bus.Funct3)
                3'b000:  w_rd = {{24{w_lane[7]}}, w_lane[7:0]};
                3'b001:  w_rd = {{16{w_lane[15]}}, w_lane[15:0]};
                3'b010:  w_rd = w_word;
                3'b100:  w_rd = {24'd0, w_lane[7:0]};
                3'b101:  w_rd = {16'd0, w_lane[15:0]};
                default: w_rd = 32'd0;
            endcase
        end
    end

    // Store lane enables and replicated store data
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.WD;
        case (bus.Funct3)
            3'b000: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.WD[7:0]}};
            end
            3'b001: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{bus.WD[15:0]}};
            end
            3'b010: begin
                w_be    = 4'b1111;
                w_wdata = bus.WD;
            end
            default: w_be = 4'b0000;
        endcase
        if (!(w_done && bus.MemWrite)) begin
            w_be = 4'b0000;
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // Wait-state FSM register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Wait-state next state: count while stalled, otherwise return to zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (w_stall) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            S_WAIT: begin
                if (w_stall) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic        r_fault;
    logic [31:0] r_fault_addr;

    // Sticky fault flag; only the first misaligned address is kept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault      <= 1'b0;
            r_fault_addr <= 32'd0;
        end else if (w_mis && !r_fault) begin
            r_fault      <= 1'b1;
            r_fault_addr <= bus.A;
        end
    end

    assign bus.Fault     = r_fault;
    assign bus.FaultAddr = r_fault_addr;
`else
    // Address bits above the RAM index wrap away when no fault address is kept
    logic w_unused_addr;
    assign w_unused_addr = ^bus.A[31:c_IDX_W+2];

    assign bus.Fault     = 1'b0;
    assign bus.FaultAddr = 32'd0;
`endif

    assign bus.RD       = w_rd;
    assign bus.Stall    = w_stall;
    assign bus.Misalign = w_mis;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Data-memory stage directly downstream of the ALU in the RV32I single-cycle core. Takes the ALU `Result` as byte address and register `RD2` as store data. Performs byte/halfword/word loads and stores with sign or zero extension against an internal word-organised RAM. A wait-state counter stretches each access and raises `Stall` to freeze the PC. Misaligned accesses are trapped, and the first faulting address is captured.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, minimum 4.
- `WAIT_CYCLES`, 0: stall cycles inserted per access; range 0..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `A`  in  32  byte address (ALU `Result`).
- `WD`  in  32  store data (`RD2`).
- `MemRead`  in  1  load request.
- `MemWrite`  in  1  store request.
- `Funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
- `RD`  out  32  extended load data.
- `Stall`  out  1  access not complete; the core must hold PC and all inputs.
- `Misalign`  out  1  current request is misaligned (combinational).
- `Fault`  out  1  sticky: a misaligned access has occurred since reset.
- `FaultAddr`  out  32  `A` of the first misaligned access.

## Operation
- Request: `req = MemRead | MemWrite`. If both are high, the store wins and `RD` = 0.
- Word index: `A[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Little-endian. Byte lane is `A[1:0]`; halfword lane is `A[1]`.
- Loads:
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.
  - Unused `Funct3` codes (011, 110, 111) return 0.
  - `RD` = 0 when no load completes.
- Stores:
  - SB writes one lane, SH two lanes, SW all four; other lanes are untouched.
  - Unused `Funct3` codes (011, 1xx) with `MemWrite` perform no write.
- Wait FSM, 4-bit counter `cnt`:
  - States: IDLE (`cnt`=0) and WAIT (`cnt`>0).
  - `Stall = req & ~Misalign & (cnt != WAIT_CYCLES)`.
  - While stalled, `cnt` increments each edge.
  - Completion cycle (`req` & `cnt`==WAIT_CYCLES): load data is valid on `RD`; the store is written at the closing edge; `cnt` is cleared to 0.
  - If `req` drops while in WAIT, `cnt` returns to 0 next edge and no write occurs.
- Misalignment:
  - Definition: H/HU with `A[0]`=1, or W with `A[1:0]`≠0.
  - The request completes immediately with no stall, no write, and `RD`=0.
  - `Misalign`=1 in that cycle.
  - At that edge, if `Fault`=0: set `Fault` and capture `FaultAddr`=`A`. Later faults do not overwrite.
- The RAM has no reset; contents persist across `rst`.

## Timing
- `WAIT_CYCLES`=0: load data is combinational from `A` in the same cycle; the store commits at that cycle's rising edge; `Stall` is never asserted.
- `WAIT_CYCLES`=N: `Stall` is high for exactly N cycles, then low for one completion cycle. Total latency is N+1 cycles per access.
- Back-to-back accesses: a new request in the cycle after completion starts from `cnt`=0.
- Reset, asynchronous and active-low:
  - `cnt`=0, `Fault`=0, `FaultAddr`=0.
  - While `rst`=0: `Stall`=0, `RD`=0, `Misalign`=0, and no RAM writes.
  - Reset asserted mid-wait aborts the access; the pending store is never written.
- Reset deassertion is sampled synchronously. The first request is accepted on the first edge with `rst`=1.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misalignment detection, `Misalign`, `Fault` and `FaultAddr` behave as specified above.
- Not defined:
  - `A[0]` is ignored for H/HU and `A[1:0]` for W; the access is forced aligned (downward).
  - `Misalign`, `Fault` and `FaultAddr` are tied to 0.
  - The stall and latency rules are unchanged.

## Test plan
- `WAIT_CYCLES`=0: SW `A`=0x10 `WD`=0xDEADBEEF, then LW 0x10 -> `RD`=0xDEADBEEF same cycle; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- Partial store: SB `A`=0x11 `WD`=0x00000055 over 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF.
- `WAIT_CYCLES`=3: LW -> `Stall` high exactly 3 cycles, `RD` valid on the 4th cycle, then `Stall` low. Drop `MemWrite` after 2 stall cycles -> memory unchanged and `cnt` back to 0.
- Misaligned (macro on): LW `A`=0x22 -> `Misalign`=1, no stall, `RD`=0, `Fault`=1 and `FaultAddr`=0x22 next cycle. A subsequent SH `A`=0x31 leaves `FaultAddr`=0x22 and memory unchanged.
- Wrap (`DEPTH`=4): SW `A`=0x0 `WD`=1, then LW `A`=0x10 -> `RD`=1.
- Reset mid-wait (`WAIT_CYCLES`=4): assert `rst`=0 during the 2nd stall cycle of SW -> `Stall`=0 immediately, `Fault`=0, the target word retains its old value.
